// File: rtl/stonyman_pkg.sv
// Shared definitions for the Stonyman capture path.
//   state_t   : capture FSM states
//   WIDTH     : pixel width
//   DEF_ROWS/DEF_COLS : default frame geometry
//   TMR_W     : width of the shared pulse/settle timer
//   cnt_w()   : counter width for a modulus, never below 1 bit
package stonyman_pkg;
  localparam int WIDTH    = 8;
  localparam int DEF_ROWS = 112;
  localparam int DEF_COLS = 112;
  localparam int TMR_W    = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST_V  = 3'd1,
    S_RST_P  = 3'd2,
    S_SETTLE = 3'd3,
    S_CONV   = 3'd4,
    S_WRITE  = 3'd5,
    S_INC_P  = 3'd6,
    S_INC_V  = 3'd7
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stonyman_pulse_timer.sv
// Down-counting wait timer shared by every pulse and settle interval.
//   clk, rst_n : clock, async active-low reset
//   start      : first cycle of a timed interval (load is sampled here)
//   load       : interval length minus one
//   busy       : a started interval is still counting
//   done       : last cycle of the interval (combinational)
// An interval started with load=N lasts exactly N+1 cycles including the
// start cycle, so load=0 gives a single-cycle interval with done on start.
module stonyman_pulse_timer
  import stonyman_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         busy,
  output logic         done
);
  logic [W-1:0] cnt;

  assign done = start ? (load == '0) : (busy && (cnt == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      // the start cycle itself already counts as the first cycle
      busy <= (load != '0);
      cnt  <= (load == '0) ? '0 : load - W'(1);
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - W'(1);
    end
  end
endmodule

// File: rtl/stonyman_capture.sv
// Sensor-side writer for the Stonyman pixel FIFO. On a start request it
// resets the row/column pointers, then scans ROWS x COLS pixels, converting
// each through an external ADC and writing it into the FIFO.
//   PCLK, PRESERN     : clock, async active-low reset
//   START_CAPTURE     : active-low frame request (one frame per low level)
//   BUSY              : frame in progress
//   FIFO_WREN/FIFO_DATA/FULL : active-low FIFO write port and full flag
//   RESP/INCP/RESV/INCV : pointer-control pins, active high, one at a time
//   INPHI             : amplifier phase, held low
//   ADC_START/ADC_DONE/ADC_DATA : single-pulse conversion handshake
module stonyman_capture
  import stonyman_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic             PCLK,
  input  logic             PRESERN,
  input  logic             START_CAPTURE,
  output logic             BUSY,
  output logic             FIFO_WREN,
  output logic [WIDTH-1:0] FIFO_DATA,
  input  logic             FULL,
  output logic             RESP,
  output logic             INCP,
  output logic             RESV,
  output logic             INCV,
  output logic             INPHI,
  output logic             ADC_START,
  input  logic             ADC_DONE,
  input  logic [WIDTH-1:0] ADC_DATA
);
  localparam int RW = cnt_w(ROWS);
  localparam int CW = cnt_w(COLS);
  localparam logic [TMR_W-1:0] LD_PULSE  = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_SETTLE = TMR_W'(SETTLE_CYC - 1);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_LAST  = CW'(COLS - 1);

  state_t             state;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic               armed;
  logic               tmr_start;
  logic [TMR_W-1:0]   tmr_load;
  logic               tmr_busy;
  logic               tmr_done;

  assign INPHI = 1'b0;

  // The FSM raises tmr_start together with the state change, so the timer
  // sees start in the first cycle of the timed state.
  stonyman_pulse_timer #(.W(TMR_W)) u_tmr (
    .clk   (PCLK),
    .rst_n (PRESERN),
    .start (tmr_start),
    .load  (tmr_load),
    .busy  (tmr_busy),
    .done  (tmr_done)
  );

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state     <= S_IDLE;
      BUSY      <= 1'b0;
      FIFO_WREN <= 1'b1;
      FIFO_DATA <= '0;
      RESP      <= 1'b0;
      INCP      <= 1'b0;
      RESV      <= 1'b0;
      INCV      <= 1'b0;
      ADC_START <= 1'b0;
      row       <= '0;
      col       <= '0;
      armed     <= 1'b0;
      tmr_start <= 1'b0;
      tmr_load  <= '0;
    end else begin
      tmr_start <= 1'b0;
      ADC_START <= 1'b0;
      FIFO_WREN <= 1'b1;
      // A request must be seen released before it can start a frame, so a
      // request held low produces exactly one frame.
      if (START_CAPTURE) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (armed && !START_CAPTURE && !tmr_busy) begin
            armed     <= 1'b0;
            BUSY      <= 1'b1;
            RESV      <= 1'b1;
            row       <= '0;
            col       <= '0;
            tmr_start <= 1'b1;
            tmr_load  <= LD_PULSE;
            state     <= S_RST_V;
          end
        end
        S_RST_V: begin
          if (tmr_done) begin
            RESV      <= 1'b0;
            RESP      <= 1'b1;
            tmr_start <= 1'b1;
            tmr_load  <= LD_PULSE;
            state     <= S_RST_P;
          end
        end
        S_RST_P: begin
          if (tmr_done) begin
            RESP      <= 1'b0;
            col       <= '0;
            tmr_start <= 1'b1;
            tmr_load  <= LD_SETTLE;
            state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (tmr_done) begin
            ADC_START <= 1'b1;
            state     <= S_CONV;
          end
        end
        S_CONV: begin
          // ADC_DONE is accepted from the ADC_START cycle onward
          if (ADC_DONE) begin
            FIFO_DATA <= ADC_DATA;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // FIFO_WREN low means the single write for this pixel is on the
          // pins this cycle; otherwise keep stalling until FULL clears.
          if (!FIFO_WREN) begin
            if (col < COL_LAST) begin
              INCP      <= 1'b1;
              tmr_start <= 1'b1;
              tmr_load  <= LD_PULSE;
              state     <= S_INC_P;
            end else if (row < ROW_LAST) begin
              INCV      <= 1'b1;
              tmr_start <= 1'b1;
              tmr_load  <= LD_PULSE;
              state     <= S_INC_V;
            end else begin
              BUSY  <= 1'b0;
              row   <= '0;
              col   <= '0;
              state <= S_IDLE;
            end
          end else if (!FULL) begin
            FIFO_WREN <= 1'b0;
          end
        end
        S_INC_P: begin
          if (tmr_done) begin
            INCP      <= 1'b0;
            col       <= col + CW'(1);
            tmr_start <= 1'b1;
            tmr_load  <= LD_SETTLE;
            state     <= S_SETTLE;
          end
        end
        S_INC_V: begin
          if (tmr_done) begin
            INCV      <= 1'b0;
            RESP      <= 1'b1;
            row       <= row + RW'(1);
            tmr_start <= 1'b1;
            tmr_load  <= LD_PULSE;
            state     <= S_RST_P;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stonyman_capture.sv
module tb_stonyman_capture;
  localparam int P    = 4;
  localparam int S    = 8;
  localparam int R    = 2;
  localparam int C    = 3;
  localparam int NPIX = R * C;
  localparam int BIGN = 112 * 112;

  logic clk;
  int   cyc;
  int   n_cmp, n_bad;

  // small instance (2x3)
  logic       s_rstn, s_start, s_busy, s_wren, s_full;
  logic [7:0] s_data, s_adcdata;
  logic       s_resp, s_incp, s_resv, s_incv, s_inphi, s_adcs, s_adcd;
  // default-size instance
  logic       b_rstn, b_start, b_busy, b_wren, b_full;
  logic [7:0] b_data, b_adcdata;
  logic       b_resp, b_incp, b_resv, b_incv, b_inphi, b_adcs, b_adcd;

  stonyman_capture #(.ROWS(R), .COLS(C), .PULSE_CYC(P), .SETTLE_CYC(S)) u_small (
    .PCLK(clk), .PRESERN(s_rstn), .START_CAPTURE(s_start), .BUSY(s_busy),
    .FIFO_WREN(s_wren), .FIFO_DATA(s_data), .FULL(s_full),
    .RESP(s_resp), .INCP(s_incp), .RESV(s_resv), .INCV(s_incv), .INPHI(s_inphi),
    .ADC_START(s_adcs), .ADC_DONE(s_adcd), .ADC_DATA(s_adcdata));

  stonyman_capture #(.PULSE_CYC(1), .SETTLE_CYC(1)) u_big (
    .PCLK(clk), .PRESERN(b_rstn), .START_CAPTURE(b_start), .BUSY(b_busy),
    .FIFO_WREN(b_wren), .FIFO_DATA(b_data), .FULL(b_full),
    .RESP(b_resp), .INCP(b_incp), .RESV(b_resv), .INCV(b_incv), .INPHI(b_inphi),
    .ADC_START(b_adcs), .ADC_DONE(b_adcd), .ADC_DATA(b_adcdata));

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- ADC / FIFO-full model for the small instance ----------
  bit         full_force, full_rand, data_mode, rand_lat;
  int         long_lat, adc_base, adc_idx;
  bit         pend;
  int         wait_n;
  logic [7:0] v;
  logic [7:0] exp_q[$];

  initial begin
    adc_idx = 0; pend = 0; wait_n = 0;
    s_adcd = 0; s_adcdata = 0; s_full = 0;
    forever begin
      @(posedge clk); #2;
      s_adcd = 0;
      if (!s_rstn) pend = 0;
      else begin
        if (s_adcs && !pend) begin
          pend = 1;
          if (adc_idx - adc_base == 0)      wait_n = 0;
          else if (adc_idx - adc_base == 1) wait_n = long_lat;
          else                              wait_n = rand_lat ? int'($urandom_range(0, 5)) : 0;
        end
        if (pend) begin
          if (wait_n == 0) begin
            v = data_mode ? 8'($urandom) : 8'(8'h10 + (adc_idx - adc_base));
            s_adcdata = v;
            s_adcd = 1;
            exp_q.push_back(v);
            adc_idx++;
            pend = 0;
          end else wait_n--;
        end
      end
      s_full = full_rand ? ($urandom_range(0, 2) == 0) : full_force;
    end
  end

  // ---------------- observers for the small instance ----------------------
  logic [7:0] got_q[$];
  int         wr_cyc[$];
  int         pulse_q[$];
  int         adcs_cyc, adcs_wide, onehot_viol, full_viol, width;
  bit         full_q, adcs_prev;
  logic [3:0] pins, prev_pins;

  initial begin
    adcs_cyc = 0; adcs_wide = 0; onehot_viol = 0; full_viol = 0; width = 0;
    full_q = 0; adcs_prev = 0; prev_pins = 0;
  end

  always @(negedge clk) begin
    if (!s_wren) begin
      got_q.push_back(s_data);
      wr_cyc.push_back(cyc);
      if (full_q) full_viol++;
    end
    full_q = s_full;
    if (s_adcs) begin
      adcs_cyc++;
      if (adcs_prev) adcs_wide++;
    end
    adcs_prev = s_adcs;
    pins = {s_resv, s_resp, s_incp, s_incv};
    if ($countones(pins) > 1) onehot_viol++;
    if (prev_pins != 0 && pins != prev_pins) pulse_q.push_back({prev_pins, 8'(width)});
    if (pins != 0) width = (pins == prev_pins) ? width + 1 : 1;
    prev_pins = pins;
  end

  // ---------------- model + observer for the default-size instance --------
  logic [7:0] b_exp[$];
  logic [7:0] bv;
  int         b_wr, b_bad;

  initial begin
    b_adcd = 0; b_adcdata = 0; b_full = 0;
    forever begin
      @(posedge clk); #2;
      b_adcd = 0;
      if (b_rstn && b_adcs) begin
        bv = 8'($urandom);
        b_adcdata = bv;
        b_adcd = 1;
        b_exp.push_back(bv);
      end
    end
  end

  initial begin b_wr = 0; b_bad = 0; end
  always @(negedge clk) begin
    if (!b_wren) begin
      b_wr++;
      if (b_exp.size() == 0) b_bad++;
      else begin
        bv = b_exp.pop_front();
        if (bv !== b_data) b_bad++;
      end
    end
  end

  // ---------------- helpers -----------------------------------------------
  int gb, eb, pb, ab;
  int exp_p[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic wait_wr(input int target, input int budget);
    int k = 0;
    while (got_q.size() < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic mark();
    gb = got_q.size(); eb = exp_q.size(); pb = pulse_q.size(); ab = adcs_cyc;
    adc_base = adc_idx;
  endtask

  task automatic start_pulse();
    @(posedge clk); #2; s_start = 0;
    @(posedge clk); #2; s_start = 1;
  endtask

  task automatic chk_ramp(input string tag);
    chk({tag, "_count"}, got_q.size() - gb, NPIX);
    for (int i = 0; i < NPIX; i++) chk({tag, "_data"}, got_q[gb+i], 8'h10 + i);
  endtask

  // ---------------- directed sequence -------------------------------------
  initial begin
    n_cmp = 0; n_bad = 0;
    s_rstn = 0; b_rstn = 0; s_start = 1; b_start = 1;
    full_force = 0; full_rand = 0; data_mode = 0; rand_lat = 0; long_lat = 0; adc_base = 0;
    repeat (3) @(posedge clk);
    #2; s_rstn = 1; b_rstn = 1;
    smp();

    // reset state
    chk("rst_busy", s_busy, 0);
    chk("rst_wren", s_wren, 1);
    chk("rst_data", s_data, 0);
    chk("rst_pins", {s_resv, s_resp, s_incp, s_incv, s_inphi, s_adcs}, 0);

    // basic frame
    mark();
    @(posedge clk); #2; s_start = 0;
    smp(); chk("busy_before_start", s_busy, 0);
    smp(); chk("busy_after_start", s_busy, 1);
    s_start = 1;
    wait_wr(gb + NPIX, 1000);
    chk_ramp("basic");
    chk("basic_cadence", wr_cyc[gb+1] - wr_cyc[gb], P + S + 3);
    smp(); chk("basic_busy_end", s_busy, 0);
    exp_p.delete();
    for (int r = 0; r < R; r++) begin
      if (r == 0) exp_p.push_back({4'b1000, 8'(P)});
      exp_p.push_back({4'b0100, 8'(P)});
      for (int c = 1; c < C; c++) exp_p.push_back({4'b0010, 8'(P)});
      if (r < R - 1) exp_p.push_back({4'b0001, 8'(P)});
    end
    chk("pulse_count", pulse_q.size() - pb, exp_p.size());
    for (int i = 0; i < exp_p.size(); i++) chk("pulse_seq", pulse_q[pb+i], exp_p[i]);
    chk("adc_start_per_pixel", adcs_cyc - ab, NPIX);
    repeat (30) smp();
    chk("basic_no_extra", got_q.size() - gb, NPIX);

    // backpressure at pixel 2
    mark(); start_pulse();
    wait_wr(gb + 2, 500);
    full_force = 1;
    repeat (20) smp();
    chk("bp_no_write", got_q.size() - gb, 2);
    chk("bp_wren_high", s_wren, 1);
    chk("bp_data_held", s_data, 8'h12);
    full_force = 0;
    wait_wr(gb + NPIX, 1000);
    chk_ramp("bp");
    chk("bp_full_viol", full_viol, 0);
    repeat (30) smp();
    chk("bp_no_extra", got_q.size() - gb, NPIX);

    // reset mid-frame, then a fresh frame
    mark(); start_pulse();
    wait_wr(gb + 2, 500);
    s_rstn = 0;
    smp();
    chk("mid_rst_busy", s_busy, 0);
    chk("mid_rst_wren", s_wren, 1);
    chk("mid_rst_data", s_data, 0);
    chk("mid_rst_pins", {s_resv, s_resp, s_incp, s_incv, s_inphi, s_adcs}, 0);
    @(posedge clk); #2; s_rstn = 1;
    repeat (2) @(posedge clk);
    mark(); start_pulse();
    wait_wr(gb + NPIX, 1000);
    chk_ramp("after_rst");
    repeat (30) smp();
    chk("after_rst_no_extra", got_q.size() - gb, NPIX);

    // request held low for 500 cycles
    mark();
    @(posedge clk); #2; s_start = 0;
    repeat (500) smp();
    s_start = 1;
    chk("held_low_count", got_q.size() - gb, NPIX);
    chk("held_low_busy", s_busy, 0);

    // request pulse in the middle of a frame
    repeat (2) @(posedge clk);
    mark(); start_pulse();
    wait_wr(gb + 2, 500);
    @(posedge clk); #2; s_start = 0;
    @(posedge clk); #2; s_start = 1;
    wait_wr(gb + NPIX, 1000);
    repeat (200) smp();
    chk("mid_pulse_count", got_q.size() - gb, NPIX);
    chk("mid_pulse_busy", s_busy, 0);

    // ADC latency 0 / 50 / random, random data, random FULL
    data_mode = 1; rand_lat = 1; long_lat = 50; full_rand = 1;
    mark(); start_pulse();
    wait_wr(gb + NPIX, 3000);
    full_rand = 0;
    chk("rand_count", got_q.size() - gb, NPIX);
    chk("rand_exp_count", exp_q.size() - eb, NPIX);
    for (int i = 0; i < NPIX; i++) chk("rand_data", got_q[gb+i], exp_q[eb+i]);
    chk("rand_adc_start_per_pixel", adcs_cyc - ab, NPIX);
    chk("adc_start_width", adcs_wide, 0);
    chk("full_write_viol", full_viol, 0);
    chk("pins_onehot", onehot_viol, 0);

    // default 112x112 frame
    @(posedge clk); #2; b_start = 0;
    @(posedge clk); #2; b_start = 1;
    begin
      int k = 0;
      while (b_wr < BIGN && k < 70000) begin smp(); k++; end
    end
    chk("big_count", b_wr, BIGN);
    chk("big_data_bad", b_bad, 0);
    smp();
    chk("big_busy_end", b_busy, 0);
    repeat (20) smp();
    chk("big_no_extra", b_wr, BIGN);
    chk("big_exp_drained", b_exp.size(), 0);
    chk("big_pins_idle", {b_resv, b_resp, b_incp, b_incv, b_inphi, b_adcs}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
